// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory slave.
// INST_MEM_RANDOM_STALL_EN widens the wait counter to cover the random extra stall.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form (taps on bits 0,2,3,5)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

`ifdef INST_MEM_RANDOM_STALL_EN
    localparam int CNT_W = 6;
`else
    localparam int CNT_W = 4;
`endif

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Program store: one write port, one registered read port; a same-index write
// on the read edge is forwarded so the reader sees the new word.
module inst_mem_array #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_mem_model.sv
// Instruction-memory slave: request latch, programmable ack latency, range check.
// Define INST_MEM_RANDOM_STALL_EN to add 0..3 LFSR-driven wait cycles per accept.
module inst_mem_model
    import inst_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 30,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 2,
    parameter logic [DATA_WIDTH-1:0] FAULT_DATA = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    InstMem_Address,
    input  logic                     InstMem_Read,
    output logic [DATA_WIDTH-1:0]    InstMem_In,
    output logic                     InstMem_Ack,
    input  logic                     Load_En,
    input  logic [$clog2(DEPTH)-1:0] Load_Addr,
    input  logic [DATA_WIDTH-1:0]    Load_Data,
    output logic                     Fault,
    output logic                     Busy
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ack;
    logic                  r_fault;
    logic                  r_busy;
    logic                  r_oor;

    logic                  w_relatch;
    logic                  w_go_ack;
    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic [ADDR_WIDTH:0]   w_diff;
    logic                  w_in_range;
    logic [IW-1:0]         w_idx;
    logic [CNT_W-1:0]      w_lat;
    logic [DATA_WIDTH-1:0] w_rdata;

`ifdef INST_MEM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_lat = CNT_W'(LATENCY) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_lat = CNT_W'(LATENCY);
`endif

    // A new request (from IDLE or an address change in WAIT) restarts the countdown.
    assign w_relatch = InstMem_Read &&
                       ((r_state == IDLE) || ((r_state == WAIT) && (InstMem_Address != r_addr)));
    assign w_go_ack  = (w_relatch && (w_lat == '0)) ||
                       ((r_state == WAIT) && InstMem_Read && (InstMem_Address == r_addr) &&
                        (r_cnt == CNT_W'(1)));

    // The extra top bit turns "address below base" into a borrow that fails the compare.
    assign w_fetch_addr = w_relatch ? InstMem_Address : r_addr;
    assign w_diff       = {1'b0, w_fetch_addr} - {1'b0, BASE_ADDR};
    assign w_in_range   = !w_diff[ADDR_WIDTH] && (w_diff < DEPTH_X);
    assign w_idx        = w_diff[IW-1:0];

    inst_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_we    (Load_En),
        .i_waddr (Load_Addr),
        .i_wdata (Load_Data),
        .i_re    (w_go_ack),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_busy <= InstMem_Read;
                    if (w_relatch) begin
                        r_addr  <= InstMem_Address;
                        r_cnt   <= w_lat;
                        r_state <= w_go_ack ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    r_busy <= InstMem_Read;
                    if (!InstMem_Read) begin
                        r_state <= IDLE;
                    end else if (w_relatch) begin
                        r_addr  <= InstMem_Address;
                        r_cnt   <= w_lat;
                        r_state <= w_go_ack ? ACK : WAIT;
                    end else if (w_go_ack) begin
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
            r_ack   <= w_go_ack;
            r_fault <= w_go_ack && !w_in_range;
            if (w_go_ack) begin
                r_oor <= !w_in_range;
            end
        end
    end

    assign InstMem_In  = r_oor ? FAULT_DATA : w_rdata;
    assign InstMem_Ack = r_ack;
    assign Fault       = r_fault;
    assign Busy        = r_busy;

endmodule

// File: tb/tb_inst_mem_model.sv
// Three slaves (latency 2 / 0 / 3, one with a shifted base) share one stimulus
// stream; an input-history model predicts ack, busy, fault and data every cycle.
module tb_inst_mem_model;

    localparam int NI = 3;
    localparam int LAT [NI] = '{2, 0, 3};
    localparam logic [29:0] BASE [NI] = '{30'h0, 30'hff8, 30'h0};
    localparam logic [31:0] PROG [3] = '{32'h20130003, 32'h20110001, 32'h02918822};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic [29:0] addr = '0;
    logic        le = 1'b0;
    logic [3:0]  la = '0;
    logic [31:0] ld = '0;

    logic [31:0]   in_o [NI];
    logic [NI-1:0] ack_o, fault_o, busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model state: length of the current run of identical, un-acked requests.
    int          run      [NI];
    logic [29:0] run_addr [NI];
    bit          prev_ack [NI];
    logic [31:0] held_in  [NI];
    logic [31:0] mem_m    [16];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        inst_mem_model #(
            .ADDR_WIDTH (30),
            .DATA_WIDTH (32),
            .DEPTH      (16),
            .BASE_ADDR  (BASE[gi]),
            .LATENCY    (LAT[gi]),
            .FAULT_DATA (32'h0)
        ) u_dut (
            .clock           (clk),
            .reset           (rst_n),
            .InstMem_Address (addr),
            .InstMem_Read    (rd),
            .InstMem_In      (in_o[gi]),
            .InstMem_Ack     (ack_o[gi]),
            .Load_En         (le),
            .Load_Addr       (la),
            .Load_Data       (ld),
            .Fault           (fault_o[gi]),
            .Busy            (busy_o[gi])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_lat(input string nm, input int got, input int nominal);
`ifdef INST_MEM_RANDOM_STALL_EN
        n_checks++;
        if (got < nominal || got > nominal + 3) begin
            n_errors++;
            $display("FAIL %s: latency %0d, required %0d..%0d", nm, got, nominal, nominal + 3);
        end
`else
        chk(nm, got, nominal);
`endif
    endtask

    // Called just after each rising edge: the live inputs are the ones that edge sampled.
    task automatic model_cycle();
        bit          e_ack, e_busy, e_fault, inr;
        longint      a, b;
        if (le) mem_m[la] = ld;
        for (int i = 0; i < NI; i++) begin
            e_ack = 0; e_busy = 0; e_fault = 0;
            if (!rst_n) begin
                run[i] = 0; prev_ack[i] = 0; held_in[i] = '0;
            end else begin
                e_busy = rd && !prev_ack[i];
                if (!rd || prev_ack[i]) run[i] = 0;
                else if (run[i] > 0 && addr == run_addr[i]) run[i]++;
                else begin run[i] = 1; run_addr[i] = addr; end
`ifdef INST_MEM_RANDOM_STALL_EN
                n_checks++;
                if ((ack_o[i] && run[i] < LAT[i] + 1) || (!ack_o[i] && run[i] >= LAT[i] + 4)) begin
                    n_errors++;
                    $display("FAIL m%0d_stall_window: ack %0d after %0d request cycles, allowed %0d..%0d",
                             i, ack_o[i], run[i], LAT[i] + 1, LAT[i] + 4);
                end
                e_ack = ack_o[i];
`else
                e_ack = (run[i] == LAT[i] + 1);
`endif
                if (e_ack) begin
                    a = longint'(run_addr[i]);
                    b = longint'(BASE[i]);
                    inr = (a >= b) && (a - b < 16);
                    held_in[i] = inr ? mem_m[(a - b) & 15] : 32'h0;
                    e_fault = !inr;
                end
                prev_ack[i] = e_ack;
            end
`ifndef INST_MEM_RANDOM_STALL_EN
            chk($sformatf("m%0d_ack", i), ack_o[i], e_ack);
`endif
            chk($sformatf("m%0d_busy", i), busy_o[i], e_busy);
            chk($sformatf("m%0d_fault", i), fault_o[i], e_fault);
            chk($sformatf("m%0d_data", i), in_o[i], held_in[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic wait_ack(input int i, input int maxk);
        bit found = 0;
        for (int k = 0; k < maxk && !found; k++) begin
            tick();
            if (ack_o[i]) found = 1;
        end
        chk($sformatf("ack%0d_seen", i), found, 1'b1);
    endtask

    function automatic logic [29:0] rand_addr();
        int sel = $urandom_range(0, 9);
        if (sel < 4) return 30'($urandom_range(0, 19));
        if (sel < 8) return 30'h0ff8 + 30'($urandom_range(0, 19));
        if (sel == 8) return 30'h0ff0 + 30'($urandom_range(0, 7));
        return 30'h3fff_fffc + 30'($urandom_range(0, 3));
    endfunction

    initial begin
        int t0;
        tick();
        tick();
        chk("rst_ack", ack_o[0], 1'b0);
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_fault", fault_o[1], 1'b0);
        chk("rst_data", in_o[0], 32'h0);
        rst_n = 1'b1;

        for (int j = 0; j < 16; j++) begin
            le = 1'b1; la = 4'(j);
            ld = (j < 3) ? PROG[j] : $urandom;
            tick();
        end
        le = 1'b0;
        tick();

        // Program fetch at latency 2, stepping the address on each ack.
        rd = 1'b1; addr = 30'd0; t0 = cyc;
        for (int j = 0; j < 3; j++) begin
            wait_ack(0, 20);
            chk_lat($sformatf("prog_lat%0d", j), cyc - t0, (j == 0) ? 3 : 4);
            chk($sformatf("prog_data%0d", j), in_o[0], PROG[j]);
            t0 = cyc;
            addr = 30'(j + 1);
        end
        rd = 1'b0;
        repeat (4) tick();

        // Out-of-range then base-mapped fetch on the shifted-base slave.
        rd = 1'b1; addr = 30'h1400; t0 = cyc;
        wait_ack(1, 8);
        chk_lat("oor_lat", cyc - t0, 1);
        chk("oor_data", in_o[1], 32'h0);
        chk("oor_fault", fault_o[1], 1'b1);
        tick();
        chk("oor_fault_pulse", fault_o[1], 1'b0);
        addr = 30'h0ff8; t0 = cyc;
        wait_ack(1, 8);
        chk_lat("base_lat", cyc - t0, 1);
        chk("base_data", in_o[1], PROG[0]);
        chk("base_fault", fault_o[1], 1'b0);
        rd = 1'b0;
        repeat (4) tick();

        // One-cycle request: aborted, no ack.
        rd = 1'b1; addr = 30'd5;
        tick();
        rd = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_ack", ack_o[2], 1'b0);
        end
        chk("abort_busy", busy_o[2], 1'b0);

        // Address change mid-WAIT restarts the countdown.
        rd = 1'b1; addr = 30'd4;
        tick();
        addr = 30'd6; t0 = cyc;
        wait_ack(0, 12);
        chk_lat("relatch_lat", cyc - t0, 3);
        chk("relatch_data", in_o[0], mem_m[6]);
        rd = 1'b0;
        repeat (4) tick();

`ifndef INST_MEM_RANDOM_STALL_EN
        // Preload hitting the fetched index on the ack-entry edge.
        rd = 1'b1; addr = 30'd7;
        tick();
        tick();
        le = 1'b1; la = 4'd7; ld = 32'hDEADBEEF;
        tick();
        le = 1'b0;
        chk("wf_ack", ack_o[0], 1'b1);
        chk("wf_data", in_o[0], 32'hDEADBEEF);
        rd = 1'b0;
        repeat (4) tick();
`endif

        // Reset during WAIT.
        rd = 1'b1; addr = 30'd1;
        tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("mrst%0d_ack", i), ack_o[i], 1'b0);
            chk($sformatf("mrst%0d_busy", i), busy_o[i], 1'b0);
            chk($sformatf("mrst%0d_fault", i), fault_o[i], 1'b0);
        end
        tick();
        rst_n = 1'b1; t0 = cyc;
        wait_ack(0, 12);
        chk_lat("post_rst_lat", cyc - t0, 3);
        chk("post_rst_data", in_o[0], PROG[1]);

        // Randomised traffic with occasional resets and preloads.
        for (int n = 0; n < 3000; n++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            rd = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 5) == 0) addr = rand_addr();
            le = rst_n && ($urandom_range(0, 4) == 0);
            la = 4'($urandom);
            ld = $urandom;
            tick();
        end
        rd = 1'b0; le = 1'b0; rst_n = 1'b1;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_model.md
Name: inst_mem_model

Overview:
- Parametrised, synthesizable instruction-memory slave for the MIPS32 core's InstMem_Read / InstMem_Address / InstMem_In / InstMem_Ack handshake.
- Replaces hand-timed instruction/ack driving in benches with a word-addressed program store, configurable ack latency, and a bench-side load port.
- Sits between the Processor instruction port and the bench or FPGA top.
- Also usable as a boot ROM.

Parameters:
- ADDR_WIDTH, 30, word-address width presented by the core.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 1024, number of stored words (power of two, ≥2).
- BASE_ADDR, 30'h0, word address that maps to index 0.
- LATENCY, 2, wait cycles between request accept and ack (0..15).
- FAULT_DATA, 32'h0000_0000, word returned for out-of-range addresses (NOP).

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- InstMem_Address, in, ADDR_WIDTH, word address from core.
- InstMem_Read, in, 1, read request level from core.
- InstMem_In, out, DATA_WIDTH, instruction to core; valid only while InstMem_Ack=1.
- InstMem_Ack, out, 1, one-cycle completion pulse.
- Load_En, in, 1, write strobe for program preload.
- Load_Addr, in, $clog2(DEPTH), preload index.
- Load_Data, in, DATA_WIDTH, preload word.
- Fault, out, 1, one-cycle pulse alongside the ack of an out-of-range access.
- Busy, out, 1, high in WAIT and ACK states.

Behaviour:
- Reset (reset=0, async): state=IDLE; InstMem_Ack=0, InstMem_In=0, Fault=0, Busy=0; wait counter=0; latched address=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, ACK; all outputs registered.
- IDLE:
  - InstMem_Read=1 → latch InstMem_Address, load counter with LATENCY, go to WAIT.
  - If LATENCY=0, go directly to ACK.
- WAIT:
  - Counter decrements each cycle; at counter=1 the next state is ACK.
  - InstMem_Read drops → abort to IDLE, no ack.
  - InstMem_Address differs from latched value → re-latch, reload counter, stay in WAIT.
- Entry to ACK:
  - Read mem[latched−BASE_ADDR] on the transition edge.
  - In range: InstMem_In=word, Fault=0.
  - Out of range (address < BASE_ADDR or ≥ BASE_ADDR+DEPTH): InstMem_In=FAULT_DATA, Fault=1.
- ACK: InstMem_Ack=1 for exactly one cycle, then unconditionally to IDLE. InstMem_In holds its value until the next ACK.
- Latency: accept edge to ack-high = LATENCY+1 cycles. Minimum spacing between acks = LATENCY+2 cycles.
- Address arithmetic: subtraction is modulo 2^ADDR_WIDTH; range compare uses an unsigned ADDR_WIDTH+1 bit result; the index is the low $clog2(DEPTH) bits.
- Load port:
  - Writes are accepted in any state.
  - A write to the same index on the ACK-entry edge is write-first: the new data is returned.
- Mid-operation reset: immediate return to IDLE; any pending ack is lost; Ack is low while reset is low.
- Busy = (state≠IDLE).

Optional Feature:
- INST_MEM_RANDOM_STALL_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1), reset to 16'hACE1, advances every cycle.
  - On each accept, its two LSBs are added to LATENCY, giving 0–3 extra wait cycles.
  - Stresses the core's stall logic.
- Undefined: latency is exactly LATENCY; no LFSR logic is present.

Decomposition:
- Package inst_mem_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - the LFSR seed and taps constant;
  - the latency counter width constant (4 bits; 6 when the stall macro is enabled).
- One sub-module, inst_mem_array: DEPTH×DATA_WIDTH register array with one write port and one synchronous read port, write-first.
- The FSM, range check and LFSR live in inst_mem_model.

Test Plan:
- Preload index 0..2 = 0x20130003, 0x20110001, 0x02918822; LATENCY=2; Read=1 at address 0 → Ack pulse 3 cycles after accept with InstMem_In=0x20130003; continuous Read gives acks at cycles 3, 7, 11 as the address steps 0→1→2.
- Same program with LATENCY=0 → ack 1 cycle after accept; back-to-back acks spaced every 2 cycles.
- BASE_ADDR=30'hff8, Read at 30'h1400 (out of range) → Ack with InstMem_In=0x00000000, Fault=1 for one cycle; Read at 30'hff8 → index 0 data, Fault=0.
- Read raised, then dropped after 1 cycle with LATENCY=3 → no Ack, Busy returns low, state IDLE; address change mid-WAIT → ack arrives LATENCY+1 cycles after the change, carrying the new word.
- Load_En writes 0xDEADBEEF to the index being fetched on the ACK-entry edge → InstMem_In=0xDEADBEEF.
- reset asserted low during WAIT → Ack, Busy, Fault low immediately; after release, a fresh request completes normally. With INST_MEM_RANDOM_STALL_EN, 100 fetches each take between LATENCY+1 and LATENCY+4 cycles, with correct data every time.
